// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller: default width,
// code-width helper and the presentation FSM states.
package irq_pkg;

  localparam int N_DEFAULT = 8;

  function automatic int code_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index-first priority encoder; an all-zero input gives code 0 and
// any_valid_o 0.
module prio_enc_lsb #(
  parameter int N      = 8,
  parameter int CODE_W = 3
) (
  input  logic [N-1:0]      vec_i,
  output logic [CODE_W-1:0] code_o,
  output logic              any_valid_o
);

  always_comb begin
    code_o      = '0;
    any_valid_o = |vec_i;
    // Scanning downward lets the lowest set index overwrite last.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) code_o = CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_priority_controller.sv
// Latches request events as pending bits and presents the highest-priority
// (lowest-index) unmasked one on a registered valid/ready handshake.
module irq_priority_controller
  import irq_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int CODE_W    = code_w(N),
  parameter int EDGE_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      mask_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N-1:0]      overrun_o,
  input  logic              ovr_clr_i
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  irq_state_e        state_q, state_d;
  logic [N-1:0]      req_d_q, pend_q, pend_d, ovr_q, ovr_d;
  logic [N-1:0]      evt, clr, hold, elig, code_oh;
  logic [CODE_W-1:0] code_q, code_d, enc_code;
  logic              valid_q, valid_d, enc_any, accept;

  always_comb begin
    evt     = (EDGE_MODE != 0) ? (req_i & ~req_d_q) : req_i;
    code_oh = ONE << code_q;
    accept  = valid_q & ready_i;
    clr     = accept ? code_oh : '0;
    pend_d  = (pend_q & ~clr) | evt;
    ovr_d   = (ovr_q & ~{N{ovr_clr_i}}) | (evt & pend_q & ~clr);
    hold    = (state_q == PRESENT && !accept) ? code_oh : '0;
    // From IDLE a fresh event is presented one edge after it turns pending;
    // after an acceptance the updated pending set is arbitrated directly.
    elig    = ((state_q == IDLE) ? pend_q : pend_d) & ~mask_i & ~hold;
  end

  prio_enc_lsb #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_enc (
    .vec_i       (elig),
    .code_o      (enc_code),
    .any_valid_o (enc_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enc_any) begin
          code_d  = enc_code;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        valid_d = 1'b1;
        if (accept) begin
          if (enc_any) begin
            code_d = enc_code;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_d_q <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_d_q <= req_i;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Directed and random checks of irq_priority_controller against a per-line
// behavioural model of pending, overrun and grant rules.
module tb_irq_priority_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_i = '0;
  logic [7:0] mask_i = '0;
  logic       ready_i = 1'b0;
  logic       ovr_clr_i = 1'b0;
  logic [2:0] code_o;
  logic       valid_o;
  logic [7:0] overrun_o;

  int n_cmp = 0;
  int n_err = 0;

  bit [7:0] m_reqd, m_pend, m_ovr;
  bit       m_valid;
  int       m_code;

  irq_priority_controller #(.N(8), .CODE_W(3), .EDGE_MODE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o),
    .ovr_clr_i (ovr_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reqd = '0; m_pend = '0; m_ovr = '0; m_valid = 0; m_code = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs now applied.
  task automatic model_step();
    bit [7:0] np;
    bit       acc, ev, cl, found;
    acc = m_valid && ready_i;
    for (int i = 0; i < 8; i++) begin
      ev = req_i[i] && !m_reqd[i];
      cl = acc && (m_code == i);
      np[i] = (m_pend[i] && !cl) || ev;
      if (ev && m_pend[i] && !cl) m_ovr[i] = 1;
      else if (ovr_clr_i) m_ovr[i] = 0;
    end
    found = 0;
    if (!m_valid) begin
      for (int i = 0; i < 8; i++)
        if (!found && m_pend[i] && !mask_i[i]) begin found = 1; m_code = i; end
      if (found) m_valid = 1;
    end else if (acc) begin
      for (int i = 0; i < 8; i++)
        if (!found && np[i] && !mask_i[i]) begin found = 1; m_code = i; end
      if (!found) m_valid = 0;
    end
    m_pend = np;
    m_reqd = req_i;
  endtask

  task automatic cyc(input logic [7:0] req, input logic [7:0] msk,
                     input logic rdy, input logic oclr);
    @(negedge clk);
    req_i = req; mask_i = msk; ready_i = rdy; ovr_clr_i = oclr;
    model_step();
    @(posedge clk);
    #1;
    check_eq("valid", int'(valid_o), int'(m_valid));
    check_eq("code", int'(code_o), m_code);
    check_eq("overrun", int'(overrun_o), int'(m_ovr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset
    for (int k = 0; k < 10; k++) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("idle_valid", int'(valid_o), 0);
    check_eq("idle_code", int'(code_o), 0);
    check_eq("idle_ovr", int'(overrun_o), 0);

    // Single event on line 5
    cyc(8'h20, 8'h00, 1'b1, 1'b0);
    check_eq("l5_not_yet", int'(valid_o), 0);
    cyc(8'h20, 8'h00, 1'b1, 1'b0);
    check_eq("l5_valid", int'(valid_o), 1);
    check_eq("l5_code", int'(code_o), 5);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("l5_drop", int'(valid_o), 0);

    // Simultaneous events 6,2,4 served in priority order
    cyc(8'h54, 8'h00, 1'b1, 1'b0);
    cyc(8'h54, 8'h00, 1'b1, 1'b0);
    check_eq("b2b_first", int'(code_o), 2);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("b2b_second", int'(code_o), 4);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("b2b_third", int'(code_o), 6);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("b2b_done", int'(valid_o), 0);

    // Presented code holds against a higher-priority arrival
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h09, 8'h00, 1'b0, 1'b0);
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    check_eq("hold_code", int'(code_o), 3);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("after_hold", int'(code_o), 0);
    check_eq("after_hold_v", int'(valid_o), 1);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);

    // Overrun on line 1, then clear
    cyc(8'h02, 8'h00, 1'b0, 1'b0);
    cyc(8'h02, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h02, 8'h00, 1'b0, 1'b0);
    check_eq("ovr_set", int'(overrun_o), 8'h02);
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("ovr_clr", int'(overrun_o), 8'h00);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);

    // Masked line 0, then unmask, then async reset mid-handshake
    cyc(8'h81, 8'h01, 1'b0, 1'b0);
    cyc(8'h81, 8'h01, 1'b0, 1'b0);
    check_eq("mask_code", int'(code_o), 7);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("unmask_code", int'(code_o), 0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", int'(valid_o), 0);
    check_eq("rst_ovr", int'(overrun_o), 0);
    model_reset();
    req_i = '0; mask_i = '0; ready_i = 1'b0; ovr_clr_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [7:0] r, m;
      r = 8'($urandom) & 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc(r, m, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
